// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer feeding the F stage.
// Issues sequential word fetches over a req/ack handshake, buffers returned
// {pc, instr} pairs in a small FIFO, presents the head to the F stage, and
// flushes/restarts on a D-stage redirect.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   imem_req     fetch request, held until imem_ack
//   imem_addr    address of the outstanding request
//   imem_ack     one-cycle response strobe, imem_rdata valid
//   imem_rdata   returned instruction word
//   Stall        F stage cannot accept the head this cycle
//   valid_F      head entry valid
//   instr_F      head instruction (zero when empty)
//   PC_F         head PC (zero when empty)
//   redirect     D-stage redirect request
//   redirect_pc  new fetch PC, word aligned

package fetch_queue_pkg;

    // One buffered fetch: PC of the word plus the returned instruction.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        Stall,
    output logic        valid_F,
    output logic [31:0] instr_F,
    output logic [31:0] PC_F,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

    // IDLE: no request outstanding; WAIT: request whose data will be kept;
    // DROP: request still outstanding whose data must be discarded.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    fq_entry_t         mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [31:0]       fpc;
    logic [31:0]       req_pc;

    logic              head_valid;
    logic              pop;
    logic              push;
    logic              room;
    logic              issue;
    logic [CNT_W:0]    count_after;

    // Handshake qualifiers; room is judged on the occupancy after this edge
    // so a request is only issued when its data is guaranteed a slot.
    always_comb begin
        head_valid  = (count != '0);
        pop         = head_valid && !Stall;
        push        = (state == S_WAIT) && imem_ack && !redirect;
        count_after = (CNT_W + 1)'(count) + (CNT_W + 1)'(push) - (CNT_W + 1)'(pop);
        room        = (count_after < DEPTH_V);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; issue marks a new request launched at this edge.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            S_IDLE: begin
                if (room && !redirect) begin
                    state_next = S_WAIT;
                    issue      = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    // A request in flight cannot be withdrawn: wait it out in DROP.
                    state_next = imem_ack ? S_IDLE : S_DROP;
                end else if (imem_ack) begin
                    if (room) begin
                        issue = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output logic: all driven from registered state only.
    always_comb begin
        fq_entry_t head;
        head      = mem[rd_ptr];
        imem_req  = (state == S_WAIT) || (state == S_DROP);
        imem_addr = req_pc;
        valid_F   = head_valid;
        instr_F   = 32'h0;
        PC_F      = 32'h0;
        if (head_valid) begin
            instr_F = head.instr;
            PC_F    = head.pc;
        end
    end

    // Fetch PC, request PC and FIFO bookkeeping. A redirect flushes after the
    // head pop, so the delay-slot instruction is consumed, not replayed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc    <= RESET_PC;
            req_pc <= 32'h0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect) begin
            fpc    <= redirect_pc;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (issue) begin
                req_pc <= fpc;
                fpc    <= fpc + 32'd4;
            end
            count <= CNT_W'(count_after);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO storage; contents are only observed through count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: req_pc, instr: imem_rdata};
        end
    end

    // The outstanding address must not move until the memory answers.
    addr_stable_a: assert property (@(posedge clk) disable iff (!reset)
        (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));

    count_bound_a: assert property (@(posedge clk) disable iff (!reset)
        count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized bench for fetch_queue with a
// request-level reference model (queue of {pc, instr} plus one outstanding
// request record) and a behavioural instruction memory of adjustable latency.
module tb_fetch_queue;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        Stall;
    logic        valid_F;
    logic [31:0] instr_F;
    logic [31:0] PC_F;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [63:0] mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_addr;
    logic        m_pend;
    logic        m_discard;

    // Memory model state.
    logic mem_busy;
    logic mem_fixed;
    int   mem_lat;
    int   mem_wait;
    int   ack_count;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .Stall       (Stall),
        .valid_F     (valid_F),
        .instr_F     (instr_F),
        .PC_F        (PC_F),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_fpc     = RST_PC;
        m_addr    = 32'h0;
        m_pend    = 1'b0;
        m_discard = 1'b0;
        mem_busy  = 1'b0;
        mem_wait  = 0;
    endtask

    // One clock of the specification's rules, applied to the model.
    task automatic model_update(input logic st, input logic rd, input logic [31:0] rpc, input logic ack);
        int   sz;
        logic do_pop, ackv, do_push, rm, pend0, disc0;
        sz      = mq.size();
        do_pop  = (sz > 0) && !st;
        ackv    = m_pend && ack;
        do_push = ackv && !m_discard && !rd;
        rm      = (sz + int'(do_push) - int'(do_pop)) < DEPTH;
        pend0   = m_pend;
        disc0   = m_discard;
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back({m_addr, data_of(m_addr)});
        if (rd) mq.delete();
        if (ackv) m_pend = 1'b0;
        else if (rd && m_pend) m_discard = 1'b1;
        if (!rd && rm && (!pend0 || (ackv && !disc0))) begin
            m_pend    = 1'b1;
            m_discard = 1'b0;
            m_addr    = m_fpc;
            m_fpc     = m_fpc + 32'd4;
        end
        if (rd) m_fpc = rpc;
    endtask

    // Called at a negedge: compare against the model, drive one cycle, advance.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic stray_ack);
        logic        ack_v;
        logic        exp_valid;
        logic [63:0] h;
        exp_valid = (mq.size() != 0);
        h = 64'h0;
        if (exp_valid) h = mq[0];
        checks += 5;
        if (valid_F !== exp_valid) begin
            failures++;
            $display("FAIL model_valid_F t=%0t got=%b exp=%b", $time, valid_F, exp_valid);
        end
        if (PC_F !== h[63:32]) begin
            failures++;
            $display("FAIL model_PC_F t=%0t got=%h exp=%h", $time, PC_F, h[63:32]);
        end
        if (instr_F !== h[31:0]) begin
            failures++;
            $display("FAIL model_instr_F t=%0t got=%h exp=%h", $time, instr_F, h[31:0]);
        end
        if (imem_req !== m_pend) begin
            failures++;
            $display("FAIL model_imem_req t=%0t got=%b exp=%b", $time, imem_req, m_pend);
        end
        if (imem_addr !== m_addr) begin
            failures++;
            $display("FAIL model_imem_addr t=%0t got=%h exp=%h", $time, imem_addr, m_addr);
        end
        ack_v = 1'b0;
        if (imem_req === 1'b1) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_wait = mem_fixed ? mem_lat : int'($urandom_range(mem_lat, 0));
            end
            if (mem_wait == 0) begin
                ack_v    = 1'b1;
                mem_busy = 1'b0;
            end else begin
                mem_wait--;
            end
        end else if (stray_ack) begin
            ack_v = 1'b1;
        end
        if (ack_v) ack_count++;
        Stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = ack_v;
        imem_rdata  = ack_v ? data_of(imem_addr) : $urandom();
        model_update(st, rd, rpc, ack_v);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        Stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        mem_fixed   = 1'b1;
        mem_lat     = 0;
        reset       = 1'b0;
        Stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        model_reset();
        #2;
        checks += 5;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req got=%b exp=0", imem_req); end
        if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_imem_addr got=%h exp=0", imem_addr); end
        if (valid_F !== 1'b0) begin failures++; $display("FAIL reset_valid_F got=%b exp=0", valid_F); end
        if (instr_F !== 32'h0) begin failures++; $display("FAIL reset_instr_F got=%h exp=0", instr_F); end
        if (PC_F !== 32'h0) begin failures++; $display("FAIL reset_PC_F got=%h exp=0", PC_F); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks += 2;
        if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", imem_req); end
        if (imem_addr !== RST_PC) begin failures++; $display("FAIL first_addr got=%h exp=%h", imem_addr, RST_PC); end
    endtask

    task automatic test_zero_wait();
        mem_fixed = 1'b1;
        mem_lat   = 0;
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks += 2;
        if (valid_F !== 1'b1) begin failures++; $display("FAIL zw_first_valid got=%b exp=1", valid_F); end
        if (PC_F !== RST_PC) begin failures++; $display("FAIL zw_first_pc got=%h exp=%h", PC_F, RST_PC); end
        for (int i = 0; i < 8; i++) begin
            checks += 2;
            if (PC_F !== RST_PC + 32'(4 * i)) begin
                failures++;
                $display("FAIL zw_head_pc i=%0d got=%h exp=%h", i, PC_F, RST_PC + 32'(4 * i));
            end
            if (imem_addr !== RST_PC + 32'(4 * i + 4)) begin
                failures++;
                $display("FAIL zw_addr i=%0d got=%h exp=%h", i, imem_addr, RST_PC + 32'(4 * i + 4));
            end
            step(1'b0, 1'b0, 32'h0, 1'b0);
        end
    endtask

    task automatic test_stall_full();
        logic found;
        mem_fixed = 1'b1;
        mem_lat   = 0;
        do_reset();
        ack_count = 0;
        repeat (12) step(1'b1, 1'b0, 32'h0, 1'b0);
        checks += 4;
        if (ack_count != 4) begin failures++; $display("FAIL stall_pushes got=%0d exp=4", ack_count); end
        if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req got=%b exp=0", imem_req); end
        if (valid_F !== 1'b1) begin failures++; $display("FAIL stall_valid got=%b exp=1", valid_F); end
        if (PC_F !== 32'h3000) begin failures++; $display("FAIL stall_head got=%h exp=00003000", PC_F); end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            if (imem_req === 1'b1) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0, 1'b0);
        end
        checks++;
        if (!found) begin failures++; $display("FAIL stall_resume timeout waiting for imem_req"); end
        else if (imem_addr !== 32'h3010) begin failures++; $display("FAIL stall_resume got=%h exp=00003010", imem_addr); end
    endtask

    task automatic test_redirect_slow();
        logic found, stop;
        int   held;
        mem_fixed = 1'b1;
        mem_lat   = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (imem_req === 1'b1 && imem_addr === 32'h3008) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0, 1'b0);
        end
        checks++;
        if (!found) begin failures++; $display("FAIL slow_req3008 timeout"); end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h3400, 1'b0);
        held = 0;
        stop = 1'b0;
        for (int i = 0; i < 10 && !stop; i++) begin
            if (imem_req !== 1'b1) stop = 1'b1;
            else begin
                checks++;
                if (imem_addr !== 32'h3008) begin failures++; $display("FAIL slow_hold_addr got=%h exp=00003008", imem_addr); end
                held++;
                step(1'b0, 1'b0, 32'h0, 1'b0);
            end
        end
        checks++;
        if (held != 2) begin failures++; $display("FAIL slow_hold_cycles got=%0d exp=2", held); end
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            if (imem_req === 1'b1) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0, 1'b0);
        end
        checks++;
        if (!found) begin failures++; $display("FAIL slow_next_req timeout"); end
        else if (imem_addr !== 32'h3400) begin failures++; $display("FAIL slow_next_req got=%h exp=00003400", imem_addr); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (valid_F === 1'b1 && PC_F === 32'h3008) begin
                failures++;
                $display("FAIL slow_dropped_shown got=%h exp=not 00003008", PC_F);
            end
            step(1'b0, 1'b0, 32'h0, 1'b0);
        end
    endtask

    task automatic test_redirect_pop();
        logic found;
        mem_fixed = 1'b1;
        mem_lat   = 0;
        do_reset();
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks += 2;
        if (valid_F !== 1'b1) begin failures++; $display("FAIL rp_pre_valid got=%b exp=1", valid_F); end
        if (PC_F !== 32'h3004) begin failures++; $display("FAIL rp_pre_head got=%h exp=00003004", PC_F); end
        step(1'b0, 1'b1, 32'h3400, 1'b0);
        checks++;
        if (valid_F !== 1'b0) begin failures++; $display("FAIL rp_flushed got=%b exp=0", valid_F); end
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            if (valid_F === 1'b1) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0, 1'b0);
        end
        checks++;
        if (!found) begin failures++; $display("FAIL rp_new_head timeout"); end
        else if (PC_F !== 32'h3400) begin failures++; $display("FAIL rp_new_head got=%h exp=00003400", PC_F); end
    endtask

    task automatic test_redirect_ack();
        mem_fixed = 1'b1;
        mem_lat   = 0;
        do_reset();
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (imem_req !== 1'b1) begin failures++; $display("FAIL ra_pre_req got=%b exp=1", imem_req); end
        step(1'b0, 1'b1, 32'h5000, 1'b0);
        checks += 2;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL ra_idle_req got=%b exp=0", imem_req); end
        if (valid_F !== 1'b0) begin failures++; $display("FAIL ra_flush got=%b exp=0", valid_F); end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks += 2;
        if (imem_req !== 1'b1) begin failures++; $display("FAIL ra_new_req got=%b exp=1", imem_req); end
        if (imem_addr !== 32'h5000) begin failures++; $display("FAIL ra_new_addr got=%h exp=00005000", imem_addr); end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (PC_F !== 32'h5000) begin failures++; $display("FAIL ra_new_head got=%h exp=00005000", PC_F); end
    endtask

    task automatic test_pc_wrap();
        logic        found;
        logic [31:0] exp_pc;
        mem_fixed = 1'b1;
        mem_lat   = 0;
        do_reset();
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            if (valid_F === 1'b1) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0, 1'b0);
        end
        checks++;
        if (!found) begin failures++; $display("FAIL wrap_valid timeout"); end
        exp_pc = 32'hFFFF_FFF8;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (PC_F !== exp_pc) begin failures++; $display("FAIL wrap_head k=%0d got=%h exp=%h", k, PC_F, exp_pc); end
            exp_pc = exp_pc + 32'd4;
            step(1'b0, 1'b0, 32'h0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        logic found;
        mem_fixed = 1'b1;
        mem_lat   = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (imem_req === 1'b1 && valid_F === 1'b1) found = 1'b1;
            else step(1'b1, 1'b0, 32'h0, 1'b0);
        end
        checks++;
        if (!found) begin failures++; $display("FAIL mid_setup timeout"); end
        reset = 1'b0;
        #1;
        checks += 5;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL mid_imem_req got=%b exp=0", imem_req); end
        if (imem_addr !== 32'h0) begin failures++; $display("FAIL mid_imem_addr got=%h exp=0", imem_addr); end
        if (valid_F !== 1'b0) begin failures++; $display("FAIL mid_valid_F got=%b exp=0", valid_F); end
        if (instr_F !== 32'h0) begin failures++; $display("FAIL mid_instr_F got=%h exp=0", instr_F); end
        if (PC_F !== 32'h0) begin failures++; $display("FAIL mid_PC_F got=%h exp=0", PC_F); end
        model_reset();
        Stall    = 1'b0;
        redirect = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks += 2;
        if (imem_req !== 1'b1) begin failures++; $display("FAIL mid_restart_req got=%b exp=1", imem_req); end
        if (imem_addr !== RST_PC) begin failures++; $display("FAIL mid_restart_addr got=%h exp=%h", imem_addr, RST_PC); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (valid_F === 1'b1) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0, 1'b0);
        end
        checks++;
        if (!found) begin failures++; $display("FAIL mid_first_head timeout"); end
        else if (PC_F !== RST_PC) begin failures++; $display("FAIL mid_first_head got=%h exp=%h", PC_F, RST_PC); end
    endtask

    task automatic test_random();
        logic        st, rd;
        logic [31:0] rpc;
        mem_fixed = 1'b0;
        mem_lat   = 3;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            st  = ($urandom_range(99, 0) < 30);
            rd  = ($urandom_range(99, 0) < 6);
            rpc = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
            step(st, rd, rpc, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall_full();
        test_redirect_slow();
        test_redirect_pop();
        test_redirect_ack();
        test_pc_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
